// File: rtl/a23_copro_pkg.sv
// -----------------------------------------------------------------------------
// a23_copro_pkg
// Shared definitions for the extended CP15 co-processor:
//   - CRn register numbers and MRC/MCR operation codes
//   - flush handshake state encoding
//   - fault FIFO entry layout
//   - helper that builds the valid-region mask for a given region count
// -----------------------------------------------------------------------------
package a23_copro_pkg;

  // Co-processor register numbers
  localparam logic [3:0] CRN_ID         = 4'd0;
  localparam logic [3:0] CRN_FLUSH      = 4'd1;
  localparam logic [3:0] CRN_CTRL       = 4'd2;
  localparam logic [3:0] CRN_CACHEABLE  = 4'd3;
  localparam logic [3:0] CRN_UPDATEABLE = 4'd4;
  localparam logic [3:0] CRN_DISRUPTIVE = 4'd5;
  localparam logic [3:0] CRN_FSTATUS    = 4'd6;
  localparam logic [3:0] CRN_FADDR      = 4'd7;
  localparam logic [3:0] CRN_FCOUNT     = 4'd8;

  // Co-processor operation codes
  localparam logic [1:0] OP_MRC = 2'd1;
  localparam logic [1:0] OP_MCR = 2'd2;

  // Cache flush handshake states
  typedef enum logic {
    FLUSH_IDLE = 1'b0,
    FLUSH_REQ  = 1'b1
  } flush_state_e;

  // One fault record: 8-bit status plus 32-bit faulting address (40 bits)
  typedef struct packed {
    logic [7:0]  status;
    logic [31:0] address;
  } fault_entry_t;

  // Mask with bits [n-1:0] set; bits at or above n are the unused regions.
  function automatic logic [31:0] region_mask(input int unsigned n);
    if (n >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/a23_fault_fifo.sv
// -----------------------------------------------------------------------------
// a23_fault_fifo
// Small FIFO of fault records with a sticky overflow flag.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_push            enqueue i_push_data (dropped and flagged when full,
//                     unless a pop happens in the same cycle)
//   i_pop             dequeue the head entry (ignored when empty)
//   i_push_data       fault record to enqueue
//   i_clr_overflow    clear the sticky overflow flag
//   o_head            oldest entry, zero when empty
//   o_empty, o_full   occupancy flags
//   o_count           number of valid entries, 0..DEPTH
//   o_overflow        sticky: a push was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module a23_fault_fifo
  import a23_copro_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  fault_entry_t i_push_data,
  input  logic         i_clr_overflow,
  output fault_entry_t o_head,
  output logic         o_empty,
  output logic         o_full,
  output logic [4:0]   o_count,
  output logic         o_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  fault_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          do_push, do_pop;

  assign o_empty    = (count_q == 5'd0);
  assign o_full     = (count_q == 5'(DEPTH));
  assign o_count    = count_q;
  assign o_overflow = overflow_q;
  assign o_head     = o_empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a value unassigned, which would otherwise infer a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    do_push = i_push && (!o_full || do_pop);

    // Pointers are power-of-two wide, so the increment wraps naturally.
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase

    // A dropped push outranks a same-cycle clear so no overflow goes unseen.
    if (i_push && !do_push) begin
      overflow_d = 1'b1;
    end else if (i_clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values regardless of statement order.
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; only the pointers and count define which entries are valid, and o_head masks the empty case.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_push_data;
  end

endmodule

// File: rtl/a23_copro15_ext.sv
// -----------------------------------------------------------------------------
// a23_copro15_ext
// Extended CP15 co-processor for the Amber core: cache control, per-region
// attribute masks, a fault status/address FIFO and a cache flush handshake.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_fetch_stall           pipeline stall; freezes register updates and pops
//   i_copro_crn             register number
//   i_copro_operation       1 = MRC (read), 2 = MCR (write)
//   i_copro_write_data      MCR data
//   i_fault, i_fault_status, i_fault_address   fault capture strobe and record
//   i_lookup_addr           address for the combinational attribute lookup
//   i_cache_flush_ack       cache finished the requested flush
//   o_copro_read_data       registered MRC data
//   o_cache_enable          cache_control[0]
//   o_cache_flush_req       flush request, held until acknowledged
//   o_copro_stall           high while a flush is outstanding
//   o_cacheable, o_updateable, o_disruptive   attributes of i_lookup_addr
// -----------------------------------------------------------------------------
module a23_copro15_ext
  import a23_copro_pkg::*;
#(
  parameter int unsigned NUM_REGIONS    = 32,
  parameter int unsigned REGION_SHIFT   = 21,
  parameter int unsigned FAULT_DEPTH    = 4,
  parameter logic [2:0]  RST_CACHE_CTRL = 3'b011,
  parameter logic [31:0] RST_CACHEABLE  = 32'h0000_0100,
  parameter logic [31:0] RST_UPDATEABLE = 32'h0000_0101,
  parameter logic [31:0] ID_VALUE       = 32'h4156_0310
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_stall,
  input  logic [3:0]  i_copro_crn,
  input  logic [1:0]  i_copro_operation,
  input  logic [31:0] i_copro_write_data,
  input  logic        i_fault,
  input  logic [7:0]  i_fault_status,
  input  logic [31:0] i_fault_address,
  input  logic [31:0] i_lookup_addr,
  input  logic        i_cache_flush_ack,
  output logic [31:0] o_copro_read_data,
  output logic        o_cache_enable,
  output logic        o_cache_flush_req,
  output logic        o_copro_stall,
  output logic        o_cacheable,
  output logic        o_updateable,
  output logic        o_disruptive
);

  localparam logic [31:0] REGION_MASK = region_mask(NUM_REGIONS);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic mcr_en, mrc_en, rd_update, flush_write;

  assign mcr_en      = !i_fetch_stall && (i_copro_operation == OP_MCR);
  assign mrc_en      = !i_fetch_stall && (i_copro_operation == OP_MRC);
  // Read data refreshes on MRC and on idle cycles, never on a write.
  assign rd_update   = !i_fetch_stall && (i_copro_operation != OP_MCR);
  assign flush_write = mcr_en && (i_copro_crn == CRN_FLUSH);

  // ---------------------------------------------------------------------------
  // Fault FIFO
  // ---------------------------------------------------------------------------
  fault_entry_t fault_in, fault_head;
  logic         fifo_empty, fifo_full, fifo_overflow;
  logic [4:0]   fifo_count;

  assign fault_in.status  = i_fault_status;
  assign fault_in.address = i_fault_address;

  a23_fault_fifo #(
    .DEPTH (FAULT_DEPTH)
  ) u_fault_fifo (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_push         (i_fault && !i_fetch_stall),
    .i_pop          (mrc_en && (i_copro_crn == CRN_FSTATUS)),
    .i_push_data    (fault_in),
    .i_clr_overflow (mcr_en && (i_copro_crn == CRN_FCOUNT)),
    .o_head         (fault_head),
    .o_empty        (fifo_empty),
    .o_full         (fifo_full),
    .o_count        (fifo_count),
    .o_overflow     (fifo_overflow)
  );

  // ---------------------------------------------------------------------------
  // Control registers and read data
  // ---------------------------------------------------------------------------
  logic [2:0]  cache_control_q, cache_control_d;
  logic [31:0] cacheable_q, cacheable_d;
  logic [31:0] updateable_q, updateable_d;
  logic [31:0] disruptive_q, disruptive_d;
  logic [31:0] read_data_q, read_data_d;

  always_comb begin
    cache_control_d = cache_control_q;
    cacheable_d     = cacheable_q;
    updateable_d    = updateable_q;
    disruptive_d    = disruptive_q;
    read_data_d     = read_data_q;

    if (mcr_en) begin
      unique case (i_copro_crn)
        CRN_CTRL:       cache_control_d = i_copro_write_data[2:0];
        CRN_CACHEABLE:  cacheable_d     = i_copro_write_data & REGION_MASK;
        CRN_UPDATEABLE: updateable_d    = i_copro_write_data & REGION_MASK;
        CRN_DISRUPTIVE: disruptive_d    = i_copro_write_data & REGION_MASK;
        default:        ;
      endcase
    end

    // Empty-FIFO reads return zero because fault_head is zeroed when empty.
    if (rd_update) begin
      unique case (i_copro_crn)
        CRN_ID:         read_data_d = ID_VALUE;
        CRN_CTRL:       read_data_d = {29'd0, cache_control_q};
        CRN_CACHEABLE:  read_data_d = cacheable_q;
        CRN_UPDATEABLE: read_data_d = updateable_q;
        CRN_DISRUPTIVE: read_data_d = disruptive_q;
        CRN_FSTATUS:    read_data_d = {24'd0, fault_head.status};
        CRN_FADDR:      read_data_d = fault_head.address;
        CRN_FCOUNT:     read_data_d = {fifo_overflow, 26'd0, fifo_count};
        default:        read_data_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cache_control_q <= RST_CACHE_CTRL;
      cacheable_q     <= RST_CACHEABLE;
      updateable_q    <= RST_UPDATEABLE;
      disruptive_q    <= 32'd0;
      read_data_q     <= 32'd0;
    end else begin
      cache_control_q <= cache_control_d;
      cacheable_q     <= cacheable_d;
      updateable_q    <= updateable_d;
      disruptive_q    <= disruptive_d;
      read_data_q     <= read_data_d;
    end
  end

  assign o_copro_read_data = read_data_q;
  assign o_cache_enable    = cache_control_q[0];

  // ---------------------------------------------------------------------------
  // Flush handshake: IDLE -> REQ on an MCR to CRn 1; a further MCR while in
  // REQ is remembered in flush_pending_q and re-issues the request after ack.
  // ---------------------------------------------------------------------------
  flush_state_e flush_state_q;
  logic         flush_pending_q;
  logic         flush_req_q;
  logic         pending_next;

  assign pending_next = flush_pending_q || flush_write;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      flush_state_q   <= FLUSH_IDLE;
      flush_pending_q <= 1'b0;
      flush_req_q     <= 1'b0;
    end else begin
      unique case (flush_state_q)
        FLUSH_IDLE: begin
          // An ack arriving here is stale and ignored.
          if (flush_write) begin
            flush_state_q <= FLUSH_REQ;
            flush_req_q   <= 1'b1;
          end
        end
        FLUSH_REQ: begin
          if (i_cache_flush_ack) begin
            if (pending_next) begin
              flush_pending_q <= 1'b0;
            end else begin
              flush_state_q <= FLUSH_IDLE;
              flush_req_q   <= 1'b0;
            end
          end else begin
            flush_pending_q <= pending_next;
          end
        end
        default: begin
          flush_state_q   <= FLUSH_IDLE;
          flush_pending_q <= 1'b0;
          flush_req_q     <= 1'b0;
        end
      endcase
    end
  end

  assign o_cache_flush_req = flush_req_q;
  assign o_copro_stall     = flush_req_q;

  // ---------------------------------------------------------------------------
  // Region attribute lookup (combinational)
  // ---------------------------------------------------------------------------
  logic [4:0] lookup_idx;
  logic       lookup_valid;
  logic       unused_lookup_bits;

  assign lookup_idx   = i_lookup_addr[REGION_SHIFT +: 5];
  assign lookup_valid = ({1'b0, lookup_idx} < 6'(NUM_REGIONS));
  // Only the region index field of the lookup address is meaningful.
  assign unused_lookup_bits = ^i_lookup_addr;

  assign o_cacheable  = lookup_valid && cacheable_q[lookup_idx] && cache_control_q[0];
  assign o_updateable = lookup_valid && updateable_q[lookup_idx];
  assign o_disruptive = lookup_valid && disruptive_q[lookup_idx];

endmodule

// File: tb/tb_a23_copro15_ext.sv
// -----------------------------------------------------------------------------
// tb_a23_copro15_ext
// Directed bench for a23_copro15_ext configured with 8 regions and a 4-entry
// fault FIFO. Each task drives one scenario and compares against hand-computed
// values. Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_a23_copro15_ext;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_WR   = 2'd2;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_fetch_stall = 1'b0;
  logic [3:0]  i_copro_crn = 4'd0;
  logic [1:0]  i_copro_operation = OP_NONE;
  logic [31:0] i_copro_write_data = 32'd0;
  logic        i_fault = 1'b0;
  logic [7:0]  i_fault_status = 8'd0;
  logic [31:0] i_fault_address = 32'd0;
  logic [31:0] i_lookup_addr = 32'd0;
  logic        i_cache_flush_ack = 1'b0;
  logic [31:0] o_copro_read_data;
  logic        o_cache_enable;
  logic        o_cache_flush_req;
  logic        o_copro_stall;
  logic        o_cacheable;
  logic        o_updateable;
  logic        o_disruptive;

  int checks   = 0;
  int failures = 0;

  a23_copro15_ext #(
    .NUM_REGIONS (8),
    .FAULT_DEPTH (4)
  ) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_fetch_stall      (i_fetch_stall),
    .i_copro_crn        (i_copro_crn),
    .i_copro_operation  (i_copro_operation),
    .i_copro_write_data (i_copro_write_data),
    .i_fault            (i_fault),
    .i_fault_status     (i_fault_status),
    .i_fault_address    (i_fault_address),
    .i_lookup_addr      (i_lookup_addr),
    .i_cache_flush_ack  (i_cache_flush_ack),
    .o_copro_read_data  (o_copro_read_data),
    .o_cache_enable     (o_cache_enable),
    .o_cache_flush_req  (o_cache_flush_req),
    .o_copro_stall      (o_copro_stall),
    .o_cacheable        (o_cacheable),
    .o_updateable       (o_updateable),
    .o_disruptive       (o_disruptive)
  );

  always #5 i_clk = ~i_clk;

  // One clock with the given operation; outputs are valid on return.
  task automatic do_op(input logic [1:0] op, input logic [3:0] crn, input logic [31:0] data);
    i_copro_operation  = op;
    i_copro_crn        = crn;
    i_copro_write_data = data;
    @(posedge i_clk);
    #1;
    i_copro_operation  = OP_NONE;
  endtask

  task automatic push_fault(input logic [7:0] status, input logic [31:0] addr);
    i_fault         = 1'b1;
    i_fault_status  = status;
    i_fault_address = addr;
    @(posedge i_clk);
    #1;
    i_fault = 1'b0;
  endtask

  // Counts cycles with o_cache_flush_req high, acking every ack_every cycles.
  task automatic run_flush(input int ack_every, output int req_cycles, output int stall_cycles);
    req_cycles   = 0;
    stall_cycles = 0;
    while (o_cache_flush_req && req_cycles < 40) begin
      req_cycles++;
      if (o_copro_stall) stall_cycles++;
      i_cache_flush_ack = ((req_cycles % ack_every) == 0);
      @(posedge i_clk);
      #1;
      i_cache_flush_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    checks++;
    if (o_copro_read_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_read_data got=%h exp=%h", o_copro_read_data, 32'd0);
    end
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    checks++;
    if (o_cache_flush_req !== 1'b0 || o_copro_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_flush got req=%b stall=%b exp=0/0", o_cache_flush_req, o_copro_stall);
    end
    do_op(OP_RD, 4'd2, 32'd0);
    checks++;
    if (o_copro_read_data !== 32'h0000_0003) begin
      failures++;
      $display("FAIL reset_ctrl got=%h exp=%h", o_copro_read_data, 32'h3);
    end
    do_op(OP_RD, 4'd3, 32'd0);
    checks++;
    if (o_copro_read_data !== 32'h0000_0100) begin
      failures++;
      $display("FAIL reset_cacheable got=%h exp=%h", o_copro_read_data, 32'h100);
    end
    do_op(OP_RD, 4'd4, 32'd0);
    checks++;
    if (o_copro_read_data !== 32'h0000_0101) begin
      failures++;
      $display("FAIL reset_updateable got=%h exp=%h", o_copro_read_data, 32'h101);
    end
    do_op(OP_RD, 4'd8, 32'd0);
    checks++;
    if (o_copro_read_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_fcount got=%h exp=%h", o_copro_read_data, 32'd0);
    end
    do_op(OP_RD, 4'd0, 32'd0);
    checks++;
    if (o_copro_read_data !== 32'h4156_0310) begin
      failures++;
      $display("FAIL id_read got=%h exp=%h", o_copro_read_data, 32'h4156_0310);
    end
    do_op(OP_RD, 4'd9, 32'd0);
    checks++;
    if (o_copro_read_data !== 32'd0) begin
      failures++;
      $display("FAIL undefined_crn got=%h exp=%h", o_copro_read_data, 32'd0);
    end
  endtask

  task automatic test_regions();
    do_op(OP_WR, 4'd3, 32'hFFFF_FFFF);
    do_op(OP_RD, 4'd3, 32'd0);
    checks++;
    if (o_copro_read_data !== 32'h0000_00FF) begin
      failures++;
      $display("FAIL mask_truncate got=%h exp=%h", o_copro_read_data, 32'hFF);
    end
    i_lookup_addr = 32'h00E0_0000;  // region 7, last valid
    #1;
    checks++;
    if (o_cacheable !== 1'b1 || o_updateable !== 1'b0 || o_disruptive !== 1'b0) begin
      failures++;
      $display("FAIL lookup_idx7 got=%b%b%b exp=100", o_cacheable, o_updateable, o_disruptive);
    end
    i_lookup_addr = 32'h0100_0000;  // region 8, out of range
    #1;
    checks++;
    if (o_cacheable !== 1'b0 || o_updateable !== 1'b0 || o_disruptive !== 1'b0) begin
      failures++;
      $display("FAIL lookup_idx8 got=%b%b%b exp=000", o_cacheable, o_updateable, o_disruptive);
    end
    i_lookup_addr = 32'h0000_1234;  // region 0
    #1;
    checks++;
    if (o_cacheable !== 1'b1 || o_updateable !== 1'b1) begin
      failures++;
      $display("FAIL lookup_idx0 got=%b%b exp=11", o_cacheable, o_updateable);
    end
    do_op(OP_WR, 4'd5, 32'h0000_0040);
    i_lookup_addr = 32'h00C0_0000;  // region 6
    #1;
    checks++;
    if (o_disruptive !== 1'b1 || o_cacheable !== 1'b1) begin
      failures++;
      $display("FAIL lookup_disruptive got=%b%b exp=11", o_disruptive, o_cacheable);
    end
    do_op(OP_WR, 4'd2, 32'h0000_0002);  // cache disabled
    #1;
    checks++;
    if (o_cacheable !== 1'b0 || o_cache_enable !== 1'b0) begin
      failures++;
      $display("FAIL cache_disable got=%b%b exp=00", o_cacheable, o_cache_enable);
    end
    do_op(OP_RD, 4'd2, 32'd0);
    checks++;
    if (o_copro_read_data !== 32'h0000_0002) begin
      failures++;
      $display("FAIL ctrl_read got=%h exp=%h", o_copro_read_data, 32'h2);
    end
  endtask

  task automatic test_stall();
    // Stalled write must be ignored and read data must hold.
    i_fetch_stall = 1'b1;
    do_op(OP_WR, 4'd2, 32'h0000_0005);
    do_op(OP_RD, 4'd0, 32'd0);
    checks++;
    if (o_copro_read_data !== 32'h0000_0002) begin
      failures++;
      $display("FAIL stall_hold got=%h exp=%h", o_copro_read_data, 32'h2);
    end
    i_fetch_stall = 1'b0;
    do_op(OP_RD, 4'd2, 32'd0);
    checks++;
    if (o_copro_read_data !== 32'h0000_0002) begin
      failures++;
      $display("FAIL stall_write_ignored got=%h exp=%h", o_copro_read_data, 32'h2);
    end
  endtask

  task automatic test_fault_overflow();
    for (int k = 1; k <= 5; k++) begin
      push_fault(8'(k), 32'hA000_0000 | 32'(k));
    end
    do_op(OP_RD, 4'd8, 32'd0);
    checks++;
    if (o_copro_read_data !== 32'h8000_0004) begin
      failures++;
      $display("FAIL overflow_count got=%h exp=%h", o_copro_read_data, 32'h8000_0004);
    end
    for (int k = 1; k <= 5; k++) begin
      logic [31:0] exp_addr;
      logic [31:0] exp_stat;
      exp_addr = (k <= 4) ? (32'hA000_0000 | 32'(k)) : 32'd0;
      exp_stat = (k <= 4) ? 32'(k) : 32'd0;
      do_op(OP_RD, 4'd7, 32'd0);
      checks++;
      if (o_copro_read_data !== exp_addr) begin
        failures++;
        $display("FAIL fault_addr_%0d got=%h exp=%h", k, o_copro_read_data, exp_addr);
      end
      do_op(OP_RD, 4'd6, 32'd0);
      checks++;
      if (o_copro_read_data !== exp_stat) begin
        failures++;
        $display("FAIL fault_status_%0d got=%h exp=%h", k, o_copro_read_data, exp_stat);
      end
    end
    do_op(OP_RD, 4'd8, 32'd0);
    checks++;
    if (o_copro_read_data !== 32'h8000_0000) begin
      failures++;
      $display("FAIL overflow_sticky got=%h exp=%h", o_copro_read_data, 32'h8000_0000);
    end
    do_op(OP_WR, 4'd8, 32'd0);
    do_op(OP_RD, 4'd8, 32'd0);
    checks++;
    if (o_copro_read_data !== 32'd0) begin
      failures++;
      $display("FAIL overflow_clear got=%h exp=%h", o_copro_read_data, 32'd0);
    end
  endtask

  task automatic test_push_pop_full();
    for (int k = 1; k <= 4; k++) begin
      push_fault(8'h10 + 8'(k), 32'hB000_0000 | 32'(k));
    end
    // Fault and CRn 6 read in the same cycle on a full FIFO.
    i_fault         = 1'b1;
    i_fault_status  = 8'h15;
    i_fault_address = 32'hB000_0005;
    do_op(OP_RD, 4'd6, 32'd0);
    i_fault = 1'b0;
    checks++;
    if (o_copro_read_data !== 32'h0000_0011) begin
      failures++;
      $display("FAIL full_pushpop_head got=%h exp=%h", o_copro_read_data, 32'h11);
    end
    do_op(OP_RD, 4'd8, 32'd0);
    checks++;
    if (o_copro_read_data !== 32'h0000_0004) begin
      failures++;
      $display("FAIL full_pushpop_count got=%h exp=%h", o_copro_read_data, 32'h4);
    end
    do_op(OP_RD, 4'd7, 32'd0);
    checks++;
    if (o_copro_read_data !== 32'hB000_0002) begin
      failures++;
      $display("FAIL full_pushpop_next got=%h exp=%h", o_copro_read_data, 32'hB000_0002);
    end
  endtask

  task automatic test_flush();
    int req_n;
    int stall_n;
    // Single flush, acked on the fifth request cycle.
    do_op(OP_WR, 4'd1, 32'd0);
    run_flush(5, req_n, stall_n);
    checks++;
    if (req_n !== 5 || stall_n !== 5) begin
      failures++;
      $display("FAIL flush_single got req=%0d stall=%0d exp=5/5", req_n, stall_n);
    end
    // Second MCR during REQ keeps the request up for another round.
    do_op(OP_WR, 4'd1, 32'd0);
    do_op(OP_WR, 4'd1, 32'd0);
    run_flush(2, req_n, stall_n);
    checks++;
    if (req_n !== 4) begin
      failures++;
      $display("FAIL flush_pending got req=%0d exp=4", req_n);
    end
    // Ack while idle must not start anything.
    i_cache_flush_ack = 1'b1;
    @(posedge i_clk);
    #1;
    i_cache_flush_ack = 1'b0;
    checks++;
    if (o_cache_flush_req !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_ack got=%b exp=0", o_cache_flush_req);
    end
  endtask

  task automatic test_reset_mid_flush();
    do_op(OP_WR, 4'd1, 32'd0);
    checks++;
    if (o_cache_flush_req !== 1'b1 || o_copro_stall !== 1'b1) begin
      failures++;
      $display("FAIL flush_start got req=%b stall=%b exp=1/1", o_cache_flush_req, o_copro_stall);
    end
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    checks++;
    if (o_cache_flush_req !== 1'b0 || o_copro_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_flush got req=%b stall=%b exp=0/0", o_cache_flush_req, o_copro_stall);
    end
    i_cache_flush_ack = 1'b1;
    @(posedge i_clk);
    #1;
    i_cache_flush_ack = 1'b0;
    @(posedge i_clk);
    #1;
    checks++;
    if (o_cache_flush_req !== 1'b0) begin
      failures++;
      $display("FAIL late_ack got req=%b exp=0", o_cache_flush_req);
    end
    // Reset also restored the masks and emptied the FIFO left by earlier tests.
    do_op(OP_RD, 4'd3, 32'd0);
    checks++;
    if (o_copro_read_data !== 32'h0000_0100) begin
      failures++;
      $display("FAIL reset_restores_mask got=%h exp=%h", o_copro_read_data, 32'h100);
    end
    do_op(OP_RD, 4'd8, 32'd0);
    checks++;
    if (o_copro_read_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_empties_fifo got=%h exp=%h", o_copro_read_data, 32'd0);
    end
  endtask

  initial begin
    test_reset();
    test_regions();
    test_stall();
    test_fault_overflow();
    test_push_pop_full();
    test_flush();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
